// File: rtl/bitswz_pkg.sv
// Shared definitions for the 9-bit swizzled word {c[2:1], d0 x3, c[0], tag}.
// Holds the word width, field positions, the default tag, the receiver
// state encoding and the decoded-result struct.
package bitswz_pkg;

  localparam int WORD_W = 9;

  localparam int C_HI   = 8;
  localparam int C_LO   = 7;
  localparam int D_HI   = 6;
  localparam int D_LO   = 4;
  localparam int C0     = 3;
  localparam int TAG_HI = 2;
  localparam int TAG_LO = 0;

  localparam logic [2:0] TAG_DEF = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] c;
    logic       d0;
    logic       tag_err;
    logic       rep_err;
  } dec_t;

endpackage

// File: rtl/bit_unswizzle_decode.sv
// Combinational decoder for one swizzled word.
// Ports:
//   word : 9-bit assembled word
//   res  : {c, d0 (majority of triplicated bit), tag_err, rep_err}
module bit_unswizzle_decode
  import bitswz_pkg::*;
#(
  parameter logic [2:0] TAG = TAG_DEF
) (
  input  logic [WORD_W-1:0] word,
  output dec_t              res
);

  logic [2:0] d;

  always_comb begin
    d           = word[D_HI:D_LO];
    res.c       = {word[C_HI], word[C_LO], word[C0]};
    res.d0      = (d[0] & d[1]) | (d[0] & d[2]) | (d[1] & d[2]);
    res.rep_err = ~((d[0] == d[1]) && (d[1] == d[2]));
    res.tag_err = (word[TAG_HI:TAG_LO] != TAG);
  end

endmodule

// File: rtl/bit_unswizzle_rx.sv
// Serial receiver / unpacker for the 9-bit swizzled word format.
// Bits arrive LSB first, one per accepted beat; sin_start marks bit 0 and
// resyncs a partial frame. Completed words are decoded into a 1-entry
// valid/ready buffer; if the buffer is occupied the receiver holds the word
// and stalls the link (sin_ready low) so nothing is lost.
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   sin_valid/sin_start/sin_data      : serial input beat
//   sin_ready                         : beat accepted this cycle
//   out_valid/out_ready               : output handshake
//   out_c/out_d0/out_tag_err/out_rep_err : decoded fields
//   abort                             : 1-cycle pulse, partial frame dropped
//   busy                              : receiver not idle
// Optional: BIT_UNSWIZZLE_DROP_BAD_EN drops tag-error words and adds the
// saturating drop_cnt output.
module bit_unswizzle_rx
  import bitswz_pkg::*;
#(
  parameter logic [2:0] TAG     = TAG_DEF,
  parameter int         TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sin_valid,
  input  logic       sin_start,
  input  logic       sin_data,
  output logic       sin_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_c,
  output logic       out_d0,
  output logic       out_tag_err,
  output logic       out_rep_err,
  output logic       abort,
  output logic       busy
`ifdef BIT_UNSWIZZLE_DROP_BAD_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  // Async assert, sync deassert of the internal reset.
  logic [1:0] rst_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_q <= 2'b00;
    else          rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];

  state_t            state, state_n;
  logic [WORD_W-1:0] w;
  logic [3:0]        cnt;
  logic [7:0]        idle_cnt;
  dec_t              res_q;
  logic [WORD_W-1:0] dec_word;
  dec_t              dec, dec_ld;
  logic              acc, buf_free, load, abort_n, drop, bad;

  assign sin_ready = (state != HOLD);
  assign busy      = (state != IDLE);
  assign acc       = sin_valid & sin_ready;
  assign buf_free  = ~out_valid | out_ready;

  // In SHIFT the last bit is still on sin_data, so decode it in flight;
  // in HOLD the full word already sits in w.
  assign dec_word = (state == HOLD) ? w : {sin_data, w[WORD_W-2:0]};

  bit_unswizzle_decode #(.TAG(TAG)) u_dec (
    .word (dec_word),
    .res  (dec)
  );

  always_comb begin
    dec_ld = dec;
`ifdef BIT_UNSWIZZLE_DROP_BAD_EN
    bad            = dec.tag_err;
    dec_ld.tag_err = 1'b0;
`else
    bad            = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    abort_n = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: if (acc && sin_start) state_n = SHIFT;
      SHIFT: begin
        if (acc && sin_start) begin
          abort_n = 1'b1;
        end else if (acc && cnt == 4'd8) begin
          if (bad) begin
            drop    = 1'b1;
            state_n = IDLE;
          end else if (buf_free) begin
            load    = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = HOLD;
          end
        end else if (!acc && idle_cnt == 8'(TIMEOUT - 1)) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end
      end
      HOLD: if (buf_free) begin
        load    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift register, bit counter and idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w        <= '0;
      cnt      <= '0;
      idle_cnt <= '0;
      abort    <= 1'b0;
    end else begin
      abort <= abort_n;
      case (state)
        IDLE: if (acc && sin_start) begin
          w[0]     <= sin_data;
          cnt      <= 4'd1;
          idle_cnt <= '0;
        end
        SHIFT: begin
          if (acc) begin
            idle_cnt <= '0;
            if (sin_start) begin
              w[0] <= sin_data;
              cnt  <= 4'd1;
            end else begin
              w[cnt] <= sin_data;
              cnt    <= cnt + 4'd1;
            end
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output buffer: a load on the handshake cycle keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      res_q     <= dec_ld;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_c       = res_q.c;
  assign out_d0      = res_q.d0;
  assign out_tag_err = res_q.tag_err;
  assign out_rep_err = res_q.rep_err;

`ifdef BIT_UNSWIZZLE_DROP_BAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_bit_unswizzle_rx.sv
// Directed bench for bit_unswizzle_rx: decode vectors, backpressure/HOLD,
// timeout, resync and reset recovery. Honours BIT_UNSWIZZLE_DROP_BAD_EN.
module tb_bit_unswizzle_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_start = 1'b0;
  logic       sin_data = 1'b0;
  logic       out_ready = 1'b0;
  logic       sin_ready, out_valid, out_d0, out_tag_err, out_rep_err, abort, busy;
  logic [2:0] out_c;
`ifdef BIT_UNSWIZZLE_DROP_BAD_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bit_unswizzle_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sin_valid   (sin_valid),
    .sin_start   (sin_start),
    .sin_data    (sin_data),
    .sin_ready   (sin_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_c       (out_c),
    .out_d0      (out_d0),
    .out_tag_err (out_tag_err),
    .out_rep_err (out_rep_err),
    .abort       (abort),
    .busy        (busy)
`ifdef BIT_UNSWIZZLE_DROP_BAD_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat; inputs change 1 time unit after the edge, sampled at the next edge.
  task automatic beat(input logic b, input logic st);
    sin_valid = 1'b1;
    sin_start = st;
    sin_data  = b;
    @(posedge clk); #1;
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  task automatic send_word(input logic [8:0] v);
    for (int i = 0; i < 9; i++) beat(v[i], i == 0);
  endtask

  task automatic check_out(input string tag, input logic [2:0] c, input logic d0,
                           input logic te, input logic re);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_c"}, out_c, c);
    check({tag, "_d0"}, out_d0, d0);
    check({tag, "_tag_err"}, out_tag_err, te);
    check({tag, "_rep_err"}, out_rep_err, re);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sin_ready"}, sin_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_c"}, out_c, 0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Consume any pending word with out_ready high.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int abort_cnt, abort_at, seen_valid;

    // Reset state
    #1;
    check_reset_vals("rst0");
    release_reset();
    check_reset_vals("rst0_rel");

    // Basic decode 0x1F5
    out_ready = 1'b1;
    send_word(9'h1F5);
    check_out("w1F5", 3'b110, 1, 0, 0);
    check("w1F5_busy", busy, 0);
    @(posedge clk); #1;
    check("w1F5_clr", out_valid, 0);

    // Repetition error 0x05D
    send_word(9'h05D);
    check_out("w05D", 3'b001, 1, 0, 1);
    drain();

    // Tag error 0x1F4
    send_word(9'h1F4);
`ifdef BIT_UNSWIZZLE_DROP_BAD_EN
    check("w1F4_drop_valid", out_valid, 0);
    check("w1F4_drop_cnt", drop_cnt, 1);
    check("w1F4_drop_busy", busy, 0);
`else
    check_out("w1F4", 3'b110, 1, 1, 0);
`endif
    drain();

    // Backpressure: two words back-to-back, consumer stalled
    out_ready = 1'b0;
    send_word(9'h1F5);
    check("bp_first_valid", out_valid, 1);
    check("bp_ready_mid", sin_ready, 1);
    send_word(9'h05D);
    check("bp_ready_held", sin_ready, 0);
    check("bp_busy_hold", busy, 1);
    check_out("bp_hold1", 3'b110, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_out("bp_hold2", 3'b110, 1, 0, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_out("bp_second", 3'b001, 1, 0, 1);
    check("bp_ready_back", sin_ready, 1);
    @(posedge clk); #1;
    check("bp_drained", out_valid, 0);

    // Timeout: 4 bits then idle; abort must fire on the 16th idle edge
    for (int i = 0; i < 4; i++) beat(1'b1, i == 0);
    check("to_busy", busy, 1);
    abort_cnt = 0; abort_at = 0; seen_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (abort) begin
        abort_cnt++;
        if (abort_at == 0) abort_at = i;
      end
      if (out_valid) seen_valid++;
    end
    check("to_abort_cnt", abort_cnt, 1);
    check("to_abort_at", abort_at, 16);
    check("to_busy_end", busy, 0);
    check("to_no_valid", seen_valid, 0);

    // Resync: start reasserted on the 5th beat
    for (int i = 0; i < 4; i++) beat(1'b0, i == 0);
    check("rs_no_abort", abort, 0);
    beat(1'b1, 1'b1);  // bit 0 of 0x1F5
    check("rs_abort", abort, 1);
    for (int i = 1; i < 9; i++) beat(9'h1F5 >> i, 1'b0);
    check("rs_abort_gone", abort, 0);
    check_out("rs_word", 3'b110, 1, 0, 0);
    drain();

    // Reset mid-frame
    for (int i = 0; i < 6; i++) beat(1'b1, i == 0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    release_reset();
    send_word(9'h05D);
    check_out("rst_mid_next", 3'b001, 1, 0, 1);
    drain();

    // Reset while in HOLD
    out_ready = 1'b0;
    send_word(9'h1F5);
    send_word(9'h05D);
    check("rst_hold_ready", sin_ready, 0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_hold");
    release_reset();
    check("rst_hold_nothing", out_valid, 0);
    out_ready = 1'b1;
    send_word(9'h1F5);
    check_out("rst_hold_next", 3'b110, 1, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bit_unswizzle_rx.md
Name: bit_unswizzle_rx

Overview:
- Serial receiver and unpacker for the 9-bit swizzled word format {c[2:1], d0 x3, c[0], 3'b101}.
- Shifts in one bit per accepted beat, LSB first, and assembles the 9-bit word.
- Checks the constant tag, majority-votes the triplicated d bit, recovers c[2:0] and d0.
- Presents each result through a 1-entry valid/ready output buffer; sits between a serial link and the consumer of the packed fields.

Parameters:
- TAG, 3'b101: expected constant in word bits [2:0].
- TIMEOUT, 16: idle cycles tolerated mid-frame before the frame is aborted; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sin_valid  in  1  serial beat valid.
- sin_start  in  1  qualifies the first bit (w[0]) of a frame.
- sin_data  in  1  serial bit.
- sin_ready  out  1  receiver accepts a beat this cycle.
- out_valid  out  1  decoded word available.
- out_ready  in  1  consumer accepts the word.
- out_c  out  3  recovered {w[8], w[7], w[3]}.
- out_d0  out  1  majority of w[6:4].
- out_tag_err  out  1  w[2:0] != TAG.
- out_rep_err  out  1  w[6:4] not all equal.
- abort  out  1  one-cycle pulse when a partial frame is discarded.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert, internal): state IDLE.
- All outputs reset to 0, except sin_ready = 1. Shift register, bit counter, idle counter and output buffer cleared.
- Beat accepted = sin_valid && sin_ready.
- IDLE:
  - Accepted beat with sin_start=1: w[0] <= sin_data, cnt <= 1, go SHIFT.
  - Accepted beat with sin_start=0: ignored, no error.
- SHIFT:
  - Each accepted beat: w[cnt] <= sin_data, cnt++. Idle counter cleared.
  - Accepted beat with sin_start=1: resync. abort pulses, w[0] <= sin_data, cnt <= 1, stay SHIFT.
  - No beat: idle counter++. On reaching TIMEOUT: abort pulses, go IDLE, partial word dropped.
  - Beat with cnt==8 completes the word:
    - If buffer free (!out_valid || out_ready): decode into buffer, out_valid=1 next cycle, go IDLE.
    - Else go HOLD.
  - Latency: out_valid rises the cycle after the 9th bit is accepted.
- HOLD:
  - sin_ready = 0; timeout counter frozen.
  - When buffer frees (!out_valid || out_ready): load decode, go IDLE.
  - Buffer slot frees and refills in the same cycle; out_valid stays high and data changes.
- sin_ready = (state != HOLD). A completed word is never lost.
- Output buffer:
  - out_* stable while out_valid && !out_ready.
  - out_valid clears on handshake unless a new word loads in the same cycle.
- Decode (combinational on the 9-bit word):
  - out_c = {w[8:7], w[3]}.
  - out_d0 = (w4&w5) | (w4&w6) | (w5&w6).
  - out_rep_err = ~(w4==w5 && w5==w6).
  - out_tag_err = (w[2:0] != TAG).
- Reset mid-frame or in HOLD: all state discarded, nothing emitted.

Optional Feature:
- Macro: BIT_UNSWIZZLE_DROP_BAD_EN.
- Defined:
  - Words with tag error never enter the buffer; out_valid is not asserted for them.
  - out_tag_err tied 0.
  - Added port drop_cnt, out, 8 bits: saturating count of dropped words, reset 0.
  - A dropped word completing in SHIFT goes directly to IDLE and never enters HOLD.
- Undefined: every completed word is presented with its flags; drop_cnt absent.

Decomposition:
- Package bitswz_pkg:
  - WORD_W=9.
  - Field index constants: C_HI=8, C_LO=7, D_HI=6, D_LO=4, C0=3, TAG_HI=2, TAG_LO=0.
  - Default TAG value 3'b101.
  - State enum {IDLE, SHIFT, HOLD}.
  - Struct for the decoded result {c, d0, tag_err, rep_err}.
- Sub-module bit_unswizzle_decode: purely combinational, 9-bit word in, decoded struct out. Reused by the parallel-path checker.

Test Plan:
- Send 0x1F5 LSB-first (1,0,1,0,1,1,1,1,1), out_ready=1. Next cycle out_valid=1, out_c=3'b110, out_d0=1, both errors 0.
- Send 0x05D. out_c=3'b001, out_d0=1, out_rep_err=1, out_tag_err=0.
- Send 0x1F4. Macro off: out_tag_err=1, out_c=3'b110. Macro on: no out_valid, drop_cnt=1.
- Backpressure: out_ready=0, send 0x1F5 then 0x05D back-to-back.
  - sin_ready drops after the 18th bit; the first word is held stable.
  - Raise out_ready: 0x1F5 then 0x05D delivered in order.
- Timeout/resync:
  - Send 4 bits, then 16 idle cycles: abort pulses once, busy=0, no out_valid.
  - Separately, sin_start at bit 5: abort pulses, the following 9 bits decode correctly.
- Reset: assert reset_n=0 after bit 6 and after entering HOLD. All outputs return to reset values immediately; the next clean frame decodes correctly.
